// File: rtl/move_pkg.sv
// Shared types for the maze move player: move directions, replay outcome
// codes, player states and a direction-to-pulse decoder.
package move_pkg;

    typedef enum logic [1:0] {
        DIR_W = 2'd0,
        DIR_N = 2'd1,
        DIR_S = 2'd2,
        DIR_E = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_WIN  = 2'd1,
        RES_LOSE = 2'd2
    } result_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // One-hot pulse vector ordered {W, N, S, E}.
    function automatic logic [3:0] dir_onehot(dir_t d);
        logic [3:0] p;
        case (d)
            DIR_W:   p = 4'b1000;
            DIR_N:   p = 4'b0100;
            DIR_S:   p = 4'b0010;
            default: p = 4'b0001;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/move_buffer.sv
// Route storage for move_player: DEPTH-entry direction register file with an
// append-only write port, a combinational read port and the move count.
module move_buffer
    import move_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_idle,
    input  logic          wr_block,
    input  logic          load_valid,
    input  dir_t          load_dir,
    input  logic [AW-1:0] rd_idx,
    output dir_t          rd_dir,
    output logic          load_ready,
    output logic [CW-1:0] count
);

    dir_t          mem_q [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          accept;

    // Appends are only taken in IDLE with room left; a start in the same
    // cycle drops the offered move, and clear overrides everything.
    assign load_ready = in_idle && (count_q < CW'(DEPTH));
    assign accept     = load_valid && load_ready && !clear && !wr_block;
    assign count      = count_q;
    assign rd_dir     = mem_q[rd_idx];

    // Next move count.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (accept) begin
            count_d = count_q + CW'(1);
        end
    end

    // Move count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Route storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[count_q[AW-1:0]] <= load_dir;
        end
    end

endmodule

// File: rtl/move_player.sv
// Replays a stored route as single-cycle one-hot W/N/S/E pulses into the
// maze FSM and stops on the first win/lose outcome or when the route runs out.
// Optional MOVE_PLAYER_STEP_EN: adds a `step` input that paces the replay
// manually instead of the GAP idle-cycle timer.
//
// state | meaning
// IDLE  | route editable, waiting for start
// PLAY  | one-cycle pulse for the current move
// WAIT  | gap after a pulse, watching win/lose
// DONE  | replay finished, result held
module move_player
    import move_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int GAP   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    input  dir_t                     load_dir,
    output logic                     load_ready,
    input  logic                     clear,
    input  logic                     start,
`ifdef MOVE_PLAYER_STEP_EN
    input  logic                     step,
`endif
    output logic                     W,
    output logic                     N,
    output logic                     S,
    output logic                     E,
    input  logic                     win,
    input  logic                     lose,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               result,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] index_q;
    logic [CW-1:0] index_d;
    logic [3:0]    pulse_q;
    logic [3:0]    pulse_d;
    result_t       result_q;
    result_t       result_d;
    logic [AW-1:0] rd_idx;
    dir_t          rd_dir;
    logic          advance;

`ifdef MOVE_PLAYER_STEP_EN
    // Manual pacing: the gap ends on an external step.
    always_comb advance = step;
`else
    localparam int GW = $clog2(GAP + 1);

    logic [GW-1:0] gap_q;
    logic [GW-1:0] gap_d;

    // Gap down-counter: loaded with GAP on PLAY, terminal count at 1 so the
    // WAIT state lasts exactly GAP cycles.
    always_comb begin
        gap_d = gap_q;
        if (clear) begin
            gap_d = '0;
        end else if (state_q == PLAY) begin
            gap_d = GW'(GAP);
        end else if (state_q == WAIT) begin
            gap_d = gap_q - GW'(1);
        end
    end

    // Gap counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end

    // The gap expires on the cycle the counter sits at its terminal count.
    always_comb advance = (gap_q == GW'(1));
`endif

    move_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_idle    (state_q == IDLE),
        .wr_block   (start),
        .load_valid (load_valid),
        .load_dir   (load_dir),
        .rd_idx     (rd_idx),
        .rd_dir     (rd_dir),
        .load_ready (load_ready),
        .count      (count)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; clear wins in every state, win beats lose.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = (count == '0) ? DONE : PLAY;
                    end
                end
                PLAY: state_d = WAIT;
                WAIT: begin
                    if (win || lose) begin
                        state_d = DONE;
                    end else if (advance) begin
                        state_d = (index_q < count) ? PLAY : DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: move index, outcome code and the pulse for the next PLAY.
    always_comb begin
        index_d  = index_q;
        result_d = result_q;
        rd_idx   = index_q[AW-1:0];
        pulse_d  = '0;
        if (clear) begin
            index_d  = '0;
            result_d = RES_NONE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        index_d  = '0;
                        result_d = RES_NONE;
                        rd_idx   = '0;
                    end
                end
                PLAY: index_d = index_q + CW'(1);
                WAIT: begin
                    if (win) begin
                        result_d = RES_WIN;
                    end else if (lose) begin
                        result_d = RES_LOSE;
                    end
                end
                default: ;
            endcase
        end
        // Pulse is registered so it is high exactly during the PLAY cycle.
        if (state_d == PLAY) begin
            pulse_d = dir_onehot(rd_dir);
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index_q  <= '0;
            result_q <= RES_NONE;
            pulse_q  <= '0;
        end else begin
            index_q  <= index_d;
            result_q <= result_d;
            pulse_q  <= pulse_d;
        end
    end

    assign {W, N, S, E} = pulse_q;
    assign busy         = (state_q == PLAY) || (state_q == WAIT);
    assign done         = (state_q == DONE);
    assign result       = result_q;

endmodule
